// File: rtl/cp0_exc_pkg.sv
// Shared CP0 definitions: exception codes, register numbers, vector and field positions.
// Used by cp0_exc and exc_prio.
package cp0_exc_pkg;

  typedef enum logic [4:0] {
    ExcInt  = 5'h00,
    ExcAdel = 5'h04,
    ExcAdes = 5'h05,
    ExcSys  = 5'h08,
    ExcBp   = 5'h09,
    ExcRi   = 5'h0a,
    ExcOv   = 5'h0c
  } exc_code_e;

  localparam logic [4:0] RegBadVAddr = 5'd8;
  localparam logic [4:0] RegCount    = 5'd9;
  localparam logic [4:0] RegCompare  = 5'd11;
  localparam logic [4:0] RegStatus   = 5'd12;
  localparam logic [4:0] RegCause    = 5'd13;
  localparam logic [4:0] RegEpc      = 5'd14;

  localparam logic [31:0] ExcVector = 32'hBFC0_0380;

  localparam int unsigned StatusIe   = 0;
  localparam int unsigned StatusExl  = 1;
  localparam int unsigned StatusImLo = 8;
  localparam int unsigned StatusImHi = 15;
  localparam int unsigned StatusBev  = 22;

  localparam int unsigned CauseCodeLo = 2;
  localparam int unsigned CauseCodeHi = 6;
  localparam int unsigned CauseSwLo   = 8;
  localparam int unsigned CauseSwHi   = 9;
  localparam int unsigned CauseHwLo   = 10;
  localparam int unsigned CauseHwHi   = 15;
  localparam int unsigned CauseBd     = 31;

  // Restart address: a delay-slot instruction restarts at its branch.
  function automatic logic [31:0] epc_of(input logic [31:0] pc, input logic bd);
    return bd ? (pc - 32'd4) : pc;
  endfunction

endpackage

// File: rtl/exc_prio.sv
// Fixed-priority exception encoder for the MEM-stage instruction; purely combinational.
module exc_prio
  import cp0_exc_pkg::*;
(
  input  logic      valid,
  input  logic      int_pend,
  input  logic      adel_inst,
  input  logic      reserve,
  input  logic      syscall,
  input  logic      brk,
  input  logic      ov,
  input  logic      adel_data,
  input  logic      ades,
  output logic      exc_valid,
  output exc_code_e exc_code
);

  always_comb begin
    exc_valid = 1'b0;
    exc_code  = ExcInt;
    if (valid) begin
      exc_valid = 1'b1;
      if (int_pend)       exc_code = ExcInt;
      else if (adel_inst) exc_code = ExcAdel;
      else if (reserve)   exc_code = ExcRi;
      else if (syscall)   exc_code = ExcSys;
      else if (brk)       exc_code = ExcBp;
      else if (ov)        exc_code = ExcOv;
      else if (adel_data) exc_code = ExcAdel;
      else if (ades)      exc_code = ExcAdes;
      else                exc_valid = 1'b0;
    end
  end

endmodule

// File: rtl/cp0_exc.sv
// CP0 exception/interrupt unit: BadVAddr, Count, Compare, Status, Cause, EPC.
// Define CP0_TIMER_INT_EN to enable the Count/Compare timer interrupt.
module cp0_exc
  import cp0_exc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        syscallM,
  input  logic        breakM,
  input  logic        reserveM,
  input  logic        eretM,
  input  logic        adel_instM,
  input  logic        adel_dataM,
  input  logic        adesM,
  input  logic        ovM,
  input  logic [5:0]  int_i,
  input  logic [31:0] pcM,
  input  logic        bdM,
  input  logic [31:0] badaddrM,
  input  logic        validM,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [4:0]  raddr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic [31:0] epc_o,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic        flush_o,
  output logic [31:0] newpc_o,
  output logic        timer_int_o
);

  logic [7:0]  status_im_q;
  logic        status_exl_q;
  logic        status_ie_q;
  logic        cause_bd_q;
  logic [5:0]  cause_ip_hw_q;
  logic [1:0]  cause_ip_sw_q;
  logic [4:0]  cause_code_q;
  logic [31:0] epc_q;
  logic [31:0] badvaddr_q;
  logic [31:0] count_q;
  logic [31:0] compare_q;

  logic      int_pend;
  logic      exc_valid;
  exc_code_e exc_code;
  logic      eret_take;
  logic      wr_en;
  logic      timer_pend;

  assign int_pend = status_ie_q & ~status_exl_q & validM &
                    (|({cause_ip_hw_q, cause_ip_sw_q} & status_im_q));

  exc_prio u_exc_prio (
    .valid     (validM),
    .int_pend  (int_pend),
    .adel_inst (adel_instM),
    .reserve   (reserveM),
    .syscall   (syscallM),
    .brk       (breakM),
    .ov        (ovM),
    .adel_data (adel_dataM),
    .ades      (adesM),
    .exc_valid (exc_valid),
    .exc_code  (exc_code)
  );

  assign eret_take = validM & eretM & ~exc_valid;
  // A redirecting instruction squashes any mtc0 issued alongside it.
  assign wr_en     = we_i & ~exc_valid & ~eret_take;
  assign flush_o   = ~rst & (exc_valid | eret_take);
  assign newpc_o   = exc_valid ? ExcVector : epc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      status_im_q   <= '0;
      status_exl_q  <= 1'b0;
      status_ie_q   <= 1'b0;
      cause_bd_q    <= 1'b0;
      cause_ip_hw_q <= '0;
      cause_ip_sw_q <= '0;
      cause_code_q  <= '0;
      epc_q         <= '0;
      badvaddr_q    <= '0;
      compare_q     <= '0;
    end else begin
      cause_ip_hw_q <= {int_i[5] | timer_pend, int_i[4:0]};
      if (exc_valid) begin
        status_exl_q <= 1'b1;
        cause_code_q <= exc_code;
        // Nested exceptions keep the original restart point.
        if (!status_exl_q) begin
          cause_bd_q <= bdM;
          epc_q      <= epc_of(pcM, bdM);
        end
        if (exc_code == ExcAdel && adel_instM) begin
          badvaddr_q <= pcM;
        end else if (exc_code == ExcAdel || exc_code == ExcAdes) begin
          badvaddr_q <= badaddrM;
        end
      end else if (eret_take) begin
        status_exl_q <= 1'b0;
      end else if (wr_en) begin
        case (waddr_i)
          RegStatus: begin
            status_im_q  <= wdata_i[StatusImHi:StatusImLo];
            status_exl_q <= wdata_i[StatusExl];
            status_ie_q  <= wdata_i[StatusIe];
          end
          RegCause:   cause_ip_sw_q <= wdata_i[CauseSwHi:CauseSwLo];
          RegEpc:     epc_q         <= wdata_i;
          RegCompare: compare_q     <= wdata_i;
          default: ;
        endcase
      end
    end
  end

`ifdef CP0_TIMER_INT_EN
  logic count_tog_q;
  logic timer_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q     <= '0;
      count_tog_q <= 1'b0;
      timer_q     <= 1'b0;
    end else begin
      count_tog_q <= ~count_tog_q;
      if (wr_en && waddr_i == RegCount) begin
        count_q <= wdata_i;
      end else if (count_tog_q) begin
        count_q <= count_q + 32'd1;
      end
      if (wr_en && waddr_i == RegCompare) begin
        timer_q <= 1'b0;
      end else if (count_q == compare_q && compare_q != '0) begin
        timer_q <= 1'b1;
      end
    end
  end

  assign timer_pend = timer_q;
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (wr_en && waddr_i == RegCount) begin
      count_q <= wdata_i;
    end
  end

  assign timer_pend = 1'b0;
`endif

  assign timer_int_o = timer_pend;

  always_comb begin
    status_o = '0;
    status_o[StatusBev]             = 1'b1;
    status_o[StatusImHi:StatusImLo] = status_im_q;
    status_o[StatusExl]             = status_exl_q;
    status_o[StatusIe]              = status_ie_q;
  end

  always_comb begin
    cause_o = '0;
    cause_o[CauseBd]                 = cause_bd_q;
    cause_o[CauseHwHi:CauseHwLo]     = cause_ip_hw_q;
    cause_o[CauseSwHi:CauseSwLo]     = cause_ip_sw_q;
    cause_o[CauseCodeHi:CauseCodeLo] = cause_code_q;
  end

  assign epc_o = epc_q;

  always_comb begin
    rdata_o = '0;
    case (raddr_i)
      RegBadVAddr: rdata_o = badvaddr_q;
      RegCount:    rdata_o = count_q;
      RegCompare:  rdata_o = compare_q;
      RegStatus:   rdata_o = status_o;
      RegCause:    rdata_o = cause_o;
      RegEpc:      rdata_o = epc_q;
      default:     rdata_o = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_exc.sv
// Self-checking bench for cp0_exc: directed scenarios then random traffic vs a behavioural model.
module tb_cp0_exc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        syscallM, breakM, reserveM, eretM;
  logic        adel_instM, adel_dataM, adesM, ovM;
  logic [5:0]  int_i;
  logic [31:0] pcM, badaddrM, wdata_i;
  logic        bdM, validM, we_i;
  logic [4:0]  waddr_i, raddr_i;
  logic [31:0] rdata_o, epc_o, status_o, cause_o, newpc_o;
  logic        flush_o, timer_int_o;

  cp0_exc dut (
    .clk         (clk),
    .rst         (rst),
    .syscallM    (syscallM),
    .breakM      (breakM),
    .reserveM    (reserveM),
    .eretM       (eretM),
    .adel_instM  (adel_instM),
    .adel_dataM  (adel_dataM),
    .adesM       (adesM),
    .ovM         (ovM),
    .int_i       (int_i),
    .pcM         (pcM),
    .bdM         (bdM),
    .badaddrM    (badaddrM),
    .validM      (validM),
    .we_i        (we_i),
    .waddr_i     (waddr_i),
    .raddr_i     (raddr_i),
    .wdata_i     (wdata_i),
    .rdata_o     (rdata_o),
    .epc_o       (epc_o),
    .status_o    (status_o),
    .cause_o     (cause_o),
    .flush_o     (flush_o),
    .newpc_o     (newpc_o),
    .timer_int_o (timer_int_o)
  );

  int checks = 0;
  int errors = 0;

  // Architectural state of the model, kept as named fields.
  logic        m_ie, m_exl, m_bd, m_tog, m_timer;
  logic [7:0]  m_im;
  logic [5:0]  m_hw;
  logic [1:0]  m_sw;
  logic [4:0]  m_code;
  logic [31:0] m_epc, m_badv, m_count, m_compare;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_status();
    return 32'h0040_0000 | ({24'd0, m_im} << 8) | ({31'd0, m_exl} << 1) | {31'd0, m_ie};
  endfunction

  function automatic logic [31:0] m_cause();
    return ({31'd0, m_bd} << 31) | ({26'd0, m_hw} << 10) | ({30'd0, m_sw} << 8) |
           ({27'd0, m_code} << 2);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd8:    return m_badv;
      5'd9:    return m_count;
      5'd11:   return m_compare;
      5'd12:   return m_status();
      5'd13:   return m_cause();
      5'd14:   return m_epc;
      default: return 32'd0;
    endcase
  endfunction

  // Walk the priority list; which = index of the winning source, -1 if none.
  function automatic void m_select(output logic tk, output logic [4:0] code, output int which);
    logic       fl[8];
    logic [4:0] cd[8];
    logic       intp;
    intp = m_ie & ~m_exl & validM & (|({m_hw, m_sw} & m_im));
    fl = '{intp, adel_instM, reserveM, syscallM, breakM, ovM, adel_dataM, adesM};
    cd = '{5'h00, 5'h04, 5'h0a, 5'h08, 5'h09, 5'h0c, 5'h04, 5'h05};
    tk = 1'b0;
    code = 5'h00;
    which = -1;
    if (validM) begin
      for (int i = 0; i < 8; i++) begin
        if (fl[i] && which < 0) begin
          tk = 1'b1;
          code = cd[i];
          which = i;
        end
      end
    end
  endfunction

  task automatic model_reset();
    m_ie = 0; m_exl = 0; m_bd = 0; m_tog = 0; m_timer = 0;
    m_im = '0; m_hw = '0; m_sw = '0; m_code = '0;
    m_epc = '0; m_badv = '0; m_count = '0; m_compare = '0;
  endtask

  task automatic model_step();
    logic tk, er, wr, ot, otog;
    logic [4:0] c;
    int w;
    logic [31:0] ocount, ocompare;
    if (rst) begin
      model_reset();
      return;
    end
    m_select(tk, c, w);
    er = validM & eretM & ~tk;
    wr = we_i & ~tk & ~er;
    ot = m_timer; otog = m_tog; ocount = m_count; ocompare = m_compare;
    if (tk) begin
      m_code = c;
      if (!m_exl) begin
        m_bd = bdM;
        m_epc = bdM ? pcM - 32'd4 : pcM;
      end
      m_exl = 1'b1;
      if (w == 1) m_badv = pcM;
      if (w == 6 || w == 7) m_badv = badaddrM;
    end
    if (er) m_exl = 1'b0;
    if (wr) begin
      case (waddr_i)
        5'd9:  m_count = wdata_i;
        5'd11: m_compare = wdata_i;
        5'd12: begin m_im = wdata_i[15:8]; m_exl = wdata_i[1]; m_ie = wdata_i[0]; end
        5'd13: m_sw = wdata_i[9:8];
        5'd14: m_epc = wdata_i;
        default: ;
      endcase
    end
    m_hw = {int_i[5] | ot, int_i[4:0]};
`ifdef CP0_TIMER_INT_EN
    if (!(wr && waddr_i == 5'd9) && otog) m_count = ocount + 32'd1;
    m_tog = ~otog;
    if (wr && waddr_i == 5'd11) m_timer = 1'b0;
    else m_timer = ot | (ocount == ocompare && ocompare != 32'd0);
`else
    if (otog || ot || ocount != ocount || ocompare != ocompare) m_timer = 1'b0;
`endif
  endtask

  task automatic set_idle();
    syscallM = 0; breakM = 0; reserveM = 0; eretM = 0;
    adel_instM = 0; adel_dataM = 0; adesM = 0; ovM = 0;
    int_i = '0; pcM = 32'hBFC0_0000; bdM = 0; badaddrM = '0; validM = 0;
    we_i = 0; waddr_i = '0; raddr_i = '0; wdata_i = '0;
  endtask

  // One clock: combinational checks at negedge, state checks just after posedge.
  task automatic cycle();
    logic tk, er;
    logic [4:0] c;
    int w;
    @(negedge clk);
    if (rst) begin
      check("flush_in_reset", {31'd0, flush_o}, 32'd0);
    end else begin
      m_select(tk, c, w);
      er = validM & eretM & ~tk;
      check("flush", {31'd0, flush_o}, {31'd0, tk | er});
      if (tk) check("newpc_exc", newpc_o, 32'hBFC0_0380);
      else if (er) check("newpc_eret", newpc_o, m_epc);
    end
    check("rdata", rdata_o, m_read(raddr_i));
    @(posedge clk);
    model_step();
    #1;
    check("status", status_o, m_status());
    check("cause", cause_o, m_cause());
    check("epc", epc_o, m_epc);
    check("timer_int", {31'd0, timer_int_o}, {31'd0, m_timer});
  endtask

  logic [4:0] addr_tab[8];
  int         n;
  logic [31:0] tmp;

  initial begin
    addr_tab = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd0, 5'd31};
    set_idle();
    model_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    // Reset must win over a simultaneous exception and write.
    syscallM = 1; validM = 1; we_i = 1; waddr_i = 5'd12; wdata_i = 32'hFFFF_FFFF;
    cycle();
    cycle();
    check("rst_status", status_o, 32'h0040_0000);
    check("rst_cause", cause_o, 32'd0);
    check("rst_epc", epc_o, 32'd0);
    rst = 1'b0;
    set_idle();
    for (int a = 7; a < 16; a++) begin
      raddr_i = 5'(a);
      cycle();
    end

    // Syscall, not in delay slot.
    set_idle(); validM = 1; syscallM = 1; pcM = 32'hBFC0_0100;
    cycle();
    check("sys_epc", epc_o, 32'hBFC0_0100);
    tmp = cause_o; check("sys_code", {27'd0, tmp[6:2]}, 32'h08);
    tmp = status_o; check("sys_exl", {31'd0, tmp[1]}, 32'd1);
    set_idle(); validM = 1; eretM = 1;
    cycle();
    tmp = status_o; check("eret_exl", {31'd0, tmp[1]}, 32'd0);

    // Overflow in a delay slot.
    set_idle(); validM = 1; ovM = 1; bdM = 1; pcM = 32'hBFC0_0208;
    cycle();
    check("ov_epc", epc_o, 32'hBFC0_0204);
    tmp = cause_o; check("ov_bd", {31'd0, tmp[31]}, 32'd1);
    check("ov_code", {27'd0, tmp[6:2]}, 32'h0c);
    set_idle(); validM = 1; eretM = 1;
    cycle();

    // Store misalign, then return.
    set_idle(); validM = 1; adesM = 1; badaddrM = 32'h8000_0003; pcM = 32'hBFC0_0300;
    cycle();
    set_idle(); raddr_i = 5'd8;
    #1;
    check("ades_badv", rdata_o, 32'h8000_0003);
    tmp = cause_o; check("ades_code", {27'd0, tmp[6:2]}, 32'h05);
    validM = 1; eretM = 1;
    #1;
    check("eret_newpc", newpc_o, 32'hBFC0_0300);
    cycle();
    tmp = status_o; check("eret2_exl", {31'd0, tmp[1]}, 32'd0);

    // Hardware interrupt with IE set, then with IE clear.
    set_idle(); we_i = 1; waddr_i = 5'd12; wdata_i = 32'h0000_FF01;
    cycle();
    set_idle(); int_i = 6'b000001;
    cycle();
    validM = 1;
    #1;
    check("int_flush", {31'd0, flush_o}, 32'd1);
    cycle();
    tmp = cause_o; check("int_code", {27'd0, tmp[6:2]}, 32'h00);
    validM = 0; we_i = 1; waddr_i = 5'd12; wdata_i = 32'h0000_FF00;
    cycle();
    we_i = 0; validM = 1;
    #1;
    check("int_masked_flush", {31'd0, flush_o}, 32'd0);
    cycle();

    // mtc0 Status dropped by a reserved-instruction exception.
    set_idle(); validM = 1; reserveM = 1; we_i = 1; waddr_i = 5'd12; wdata_i = 32'h0000_0001;
    cycle();
    check("ri_status", status_o, 32'h0040_FF02);
    tmp = cause_o; check("ri_code", {27'd0, tmp[6:2]}, 32'h0a);

    // Timer: Compare=10, Count=0.
    set_idle(); we_i = 1; waddr_i = 5'd11; wdata_i = 32'd10;
    cycle();
    waddr_i = 5'd9; wdata_i = 32'd0;
    cycle();
    set_idle(); raddr_i = 5'd9;
    n = 0;
    while (!timer_int_o && n < 40) begin
      cycle();
      n++;
    end
`ifdef CP0_TIMER_INT_EN
    checks++;
    assert (n >= 18 && n <= 24) else begin
      errors++;
      $error("FAIL timer_latency: got %0d cycles expected 18..24", n);
    end
    we_i = 1; waddr_i = 5'd11; wdata_i = 32'h100;
    cycle();
    check("timer_clear", {31'd0, timer_int_o}, 32'd0);
`else
    check("timer_off", {31'd0, timer_int_o}, 32'd0);
    check("count_held", rdata_o, 32'd0);
`endif

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      rst        = ($urandom_range(0, 99) == 0);
      validM     = ($urandom_range(0, 7) != 0);
      syscallM   = ($urandom_range(0, 15) == 0);
      breakM     = ($urandom_range(0, 15) == 0);
      reserveM   = ($urandom_range(0, 15) == 0);
      eretM      = ($urandom_range(0, 9) == 0);
      adel_instM = ($urandom_range(0, 15) == 0);
      adel_dataM = ($urandom_range(0, 15) == 0);
      adesM      = ($urandom_range(0, 15) == 0);
      ovM        = ($urandom_range(0, 15) == 0);
      int_i      = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
      pcM        = $urandom;
      bdM        = 1'($urandom_range(0, 1));
      badaddrM   = $urandom;
      we_i       = ($urandom_range(0, 2) == 0);
      waddr_i    = addr_tab[$urandom_range(0, 7)];
      wdata_i    = $urandom;
      raddr_i    = ($urandom_range(0, 3) == 0) ? 5'($urandom) : addr_tab[$urandom_range(0, 7)];
      cycle();
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
